// File: rtl/cacheline_adaptor.sv
// rtl/cacheline_adaptor.sv - cacheline to 4-beat burst adaptor; optional timeout abort under ADAPTOR_TIMEOUT_EN
module cacheline_adaptor #(
  parameter int LINE_WIDTH     = 256,
  parameter int BURST_WIDTH    = 64,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [31:0]            address_i,
  input  logic                   read_i,
  input  logic                   write_i,
  input  logic [LINE_WIDTH-1:0]  line_i,
  output logic [LINE_WIDTH-1:0]  line_o,
  output logic                   resp_o,
  output logic                   err_o,
  output logic [31:0]            address_o,
  output logic                   read_o,
  output logic                   write_o,
  output logic [BURST_WIDTH-1:0] burst_o,
  input  logic [BURST_WIDTH-1:0] burst_i,
  input  logic                   resp_i
);

  localparam int         BEATS = LINE_WIDTH / BURST_WIDTH;
  localparam logic [1:0] LAST  = 2'(BEATS - 1);

  // The 2-bit beat counter bounds the line to at most four beats.
  if (BEATS * BURST_WIDTH != LINE_WIDTH || BEATS < 1 || BEATS > 4 || TIMEOUT_CYCLES < 1) begin : g_cfg_check
    $error("cacheline_adaptor: unsupported parameter combination");
  end

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

  state_t                 state_q, state_d;
  logic [1:0]             cnt_q, cnt_d;
  logic [31:0]            addr_q, addr_d;
  logic [LINE_WIDTH-1:0]  line_q, line_d;
  logic [LINE_WIDTH-1:0]  wbuf_q, wbuf_d;
  logic                   err_q, err_d;
  logic                   busy;

  assign busy = (state_q == RD) || (state_q == WR);

`ifdef ADAPTOR_TIMEOUT_EN
  logic [31:0] idle_q, idle_d;

  // Cycles since the last beat; zero outside a burst so entry starts from zero.
  always_comb begin
    idle_d = 32'd0;
    if (busy && !resp_i) idle_d = idle_q + 32'd1;
  end

  // Idle counter register.
  always_ff @(posedge clk) begin
    if (rst) idle_q <= 32'd0;
    else     idle_q <= idle_d;
  end
`endif

  // Next-state logic: request capture, beat accounting, completion.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    line_d  = line_q;
    wbuf_d  = wbuf_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (read_i) begin
          addr_d  = address_i & ~32'h0000_001f;
          cnt_d   = 2'd0;
          state_d = RD;
        end else if (write_i) begin
          addr_d  = address_i & ~32'h0000_001f;
          wbuf_d  = line_i;
          cnt_d   = 2'd0;
          state_d = WR;
        end
      end
      RD: begin
        if (resp_i) begin
          line_d[int'(cnt_q)*BURST_WIDTH +: BURST_WIDTH] = burst_i;
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == LAST) state_d = DONE;
        end
      end
      WR: begin
        if (resp_i) begin
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == LAST) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
`ifdef ADAPTOR_TIMEOUT_EN
    // A beat arriving on the expiry cycle still counts; only silence aborts.
    if (busy && !resp_i && idle_q == 32'(TIMEOUT_CYCLES - 1)) begin
      state_d = DONE;
      err_d   = 1'b1;
    end
`endif
  end

  // State and datapath registers; reset clears everything, including mid-burst.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
      addr_q  <= 32'd0;
      line_q  <= '0;
      wbuf_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      line_q  <= line_d;
      wbuf_q  <= wbuf_d;
      err_q   <= err_d;
    end
  end

  assign read_o    = (state_q == RD);
  assign write_o   = (state_q == WR);
  assign resp_o    = (state_q == DONE);
  assign address_o = addr_q;
  assign line_o    = line_q;
  assign burst_o   = wbuf_q[int'(cnt_q)*BURST_WIDTH +: BURST_WIDTH];

`ifdef ADAPTOR_TIMEOUT_EN
  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: doc/cacheline_adaptor.md
Name: cacheline_adaptor

Overview:
Responder on the cache's physical-memory line interface.
- Accepts a 256-bit cacheline read or write request from the cache.
- Converts it into a 4-beat, 64-bit burst transaction on the main-memory bus.
- Pulses a one-cycle response to the cache when the burst completes.
- Sits between the L1 cache's pmem port and the memory model/arbiter.

Parameters:
LINE_WIDTH, 256, cacheline width in bits; must be a multiple of BURST_WIDTH.
BURST_WIDTH, 64, memory bus beat width in bits; BEATS = LINE_WIDTH/BURST_WIDTH = 4.
TIMEOUT_CYCLES, 1024, cycles without resp_i before abort; used only with the optional feature.

Ports:
clk  input  1  clock; all state changes on the rising edge.
rst  input  1  synchronous, active-high reset.
address_i  input  32  line address from the cache; bits [4:0] are ignored.
read_i  input  1  cache line-read request; held until resp_o.
write_i  input  1  cache line-write request; held until resp_o.
line_i  input  LINE_WIDTH  write data from the cache.
line_o  output  LINE_WIDTH  read data to the cache.
resp_o  output  1  one-cycle completion pulse to the cache.
err_o  output  1  timeout abort flag; valid with resp_o.
address_o  output  32  burst address to memory.
read_o  output  1  memory burst read request.
write_o  output  1  memory burst write request.
burst_o  output  BURST_WIDTH  write beat to memory.
burst_i  input  BURST_WIDTH  read beat from memory.
resp_i  input  1  memory beat acknowledge; one beat per high cycle.

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst).
- FSM states: IDLE, RD, WR, DONE. Beat counter cnt is 2 bits, counting 0..BEATS-1.
- Reset values:
  - state=IDLE, cnt=0.
  - read_o, write_o, resp_o and err_o are 0.
  - address_o=0, burst_o=0, line_o=0.
  - The write buffer is cleared to 0.
- Reset wins over every other event, including mid-burst. read_o/write_o drop in the cycle after the reset edge.
- IDLE:
  - If read_i=1: latch address_o={address_i[31:5],5'b0}, cnt=0, go to RD.
  - Else if write_i=1: latch the same address, latch line_i into the write buffer, cnt=0, go to WR.
  - If both are asserted, read wins; this is an illegal stimulus, but the outcome is deterministic.
- RD:
  - read_o=1.
  - On each resp_i=1: line_o[cnt*64 +: 64] <= burst_i, cnt++.
  - When resp_i=1 with cnt=3: go to DONE.
  - Gaps (resp_i=0) between beats are legal; cnt holds during a gap.
- WR:
  - write_o=1.
  - burst_o = wbuf[cnt*64 +: 64], combinational from cnt.
  - cnt++ on resp_i=1; when resp_i=1 with cnt=3, go to DONE.
- DONE:
  - resp_o=1 for exactly one cycle; read_o=write_o=0.
  - Requests are not sampled in DONE; next state is IDLE.
- Request acceptance: a request is accepted no earlier than the cycle after DONE. Back-to-back requests therefore cost one IDLE cycle.
- Minimum latency, with resp_i high every cycle:
  - Request sampled at edge k.
  - read_o/write_o high in cycles k+1..k+4.
  - resp_o high in cycle k+5.
- line_o:
  - Holds the last fully or partially read line until overwritten by a later read.
  - A write does not modify line_o.
- address_o is stable for the whole burst. Changes to address_i/line_i after acceptance are ignored.
- resp_i outside RD/WR is ignored.

Optional Feature:
Macro ADAPTOR_TIMEOUT_EN.
- With the macro defined:
  - A 32-bit idle counter clears on entry to RD/WR and on every resp_i beat, and increments otherwise while in RD/WR.
  - When the counter reaches TIMEOUT_CYCLES, the FSM goes to DONE and asserts err_o=1 together with resp_o for that one cycle.
  - Beats not received keep their previous line_o contents.
- Without the macro: no counter is built, err_o is tied to 0, and a missing resp_i stalls the FSM indefinitely.

Test Plan:
- Read, resp_i every cycle:
  - Stimulus: read_i with address_i=0x0000_1234; burst_i = 0x1111..., 0x2222..., 0x3333..., 0x4444....
  - Required response: address_o=0x0000_1220; read_o high for 4 cycles; resp_o pulses in cycle k+5; line_o={0x4444...,0x3333...,0x2222...,0x1111...}.
- Write with stalls:
  - Stimulus: write_i with line_i={D3,D2,D1,D0}; resp_i pattern 1,0,0,1,1,0,1.
  - Required response: burst_o shows D0,D1,D1,D1,D2,D3,D3 on those cycles; write_o drops after the 4th ack; resp_o fires once; line_o unchanged.
- Back-to-back:
  - Stimulus: write then read, each held until resp_o.
  - Required response: exactly one IDLE cycle between the bursts; the second address_o is latched correctly.
- Reset mid-burst:
  - Stimulus: rst asserted after 2 read beats.
  - Required response: next cycle read_o=0, line_o=0, resp_o=0; a new read then completes normally with cnt starting at 0.
- Simultaneous read_i and write_i:
  - Stimulus: both asserted in IDLE.
  - Required response: read burst performed; write_o never asserted.
- With ADAPTOR_TIMEOUT_EN and TIMEOUT_CYCLES=16:
  - Stimulus: read, 1 beat, then resp_i held at 0.
  - Required response: resp_o=err_o=1 exactly 16 cycles after the last beat; FSM back in IDLE next cycle.
